// File: rtl/result_ddr_writeback_control_if.sv
// Result buffer / DDR write port bundle for result_ddr_writeback_control.
// master = writeback controller side, slave = buffer/DDR/host side.
interface result_ddr_writeback_control_if #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24
);
  logic                    conf;
  logic [SINGLE_LEN-1:0]   line_num;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr;
  logic [ADDR_LEN-1:0]     rb_st_addr;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic [ADDR_LEN-1:0]     rb_addr;
  logic                    rb_rd_en;
  logic [DATA_LEN*8-1:0]   rb_data;
  logic                    ddr_fifo_full;
  logic                    ddr_fifo_wr;
  logic [DATA_LEN*8-1:0]   ddr_fifo_data;
  logic                    done;
  logic                    idle;

  modport master (
    input  conf, line_num, ddr_st_addr, rb_st_addr, rb_data, ddr_fifo_full,
    output ddr_st_addr_out, ddr_len, ddr_conf, rb_addr, rb_rd_en,
           ddr_fifo_wr, ddr_fifo_data, done, idle
  );
  modport slave (
    output conf, line_num, ddr_st_addr, rb_st_addr, rb_data, ddr_fifo_full,
    input  ddr_st_addr_out, ddr_len, ddr_conf, rb_addr, rb_rd_en,
           ddr_fifo_wr, ddr_fifo_data, done, idle
  );
endinterface

// File: rtl/result_ddr_writeback_control.sv
// Result buffer -> DDR write FIFO mover with 1-cycle read latency and 2-entry skid.
// Optional macro WB_LANE_REVERSE_EN reverses the 8 DATA_LEN lanes of each written line.
module result_ddr_writeback_control #(
  parameter int DDR_ADDR_LEN = 32,
  parameter int ADDR_LEN     = 16,
  parameter int DATA_LEN     = 64,
  parameter int SINGLE_LEN   = 24
) (
  input  logic clk,
  input  logic rst_n,
  result_ddr_writeback_control_if.master bus
);
  localparam int LINE_W = DATA_LEN * 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  r_state, w_state_nxt;
  logic [SINGLE_LEN-1:0]   r_line_num, r_lines_read;
  logic [ADDR_LEN-1:0]     r_rb_st;
  logic [DDR_ADDR_LEN-1:0] r_ddr_addr;
  logic [SINGLE_LEN-1:0]   r_ddr_len;
  logic                    r_ddr_conf;
  logic                    r_inflight;
  logic [1:0]              r_skid_cnt;
  logic [LINE_W-1:0]       r_skid0, r_skid1;

  logic                    w_accept, w_rd_en, w_has_skid, w_wr, w_pop, w_push;
  logic [1:0]              w_occ;
  logic [LINE_W-1:0]       w_rb_lanes, w_wr_data;
  logic [7:0][DATA_LEN-1:0] w_in_lanes, w_out_lanes;

  assign w_in_lanes = bus.rb_data;
  for (genvar k = 0; k < 8; k++) begin : g_lane
`ifdef WB_LANE_REVERSE_EN
    assign w_out_lanes[k] = w_in_lanes[7-k];
`else
    assign w_out_lanes[k] = w_in_lanes[k];
`endif
  end
  assign w_rb_lanes = w_out_lanes;

  // Returning read data bypasses the skid only when nothing older is queued.
  assign w_has_skid = (r_skid_cnt != 2'd0);
  assign w_occ      = r_skid_cnt + {1'b0, r_inflight};
  assign w_wr       = !bus.ddr_fifo_full && (w_has_skid || r_inflight);
  assign w_pop      = w_has_skid && !bus.ddr_fifo_full;
  assign w_push     = r_inflight && !(w_wr && !w_has_skid);
  assign w_wr_data  = w_has_skid ? r_skid0 : (r_inflight ? w_rb_lanes : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_rd_en     = 1'b0;
    case (r_state)
      S_IDLE: if (bus.conf) begin
        w_accept    = 1'b1;
        w_state_nxt = (bus.line_num == '0) ? S_DONE : S_READ;
      end
      S_READ: begin
        w_rd_en = (r_lines_read < r_line_num) && (w_occ < 2'd2);
        if (w_rd_en && (r_lines_read + SINGLE_LEN'(1) == r_line_num)) w_state_nxt = S_DRAIN;
      end
      // All reads issued: the job ends with the write that empties skid+inflight.
      S_DRAIN: if (w_wr && (w_occ == 2'd1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_line_num   <= '0;
      r_lines_read <= '0;
      r_rb_st      <= '0;
      r_ddr_addr   <= '0;
      r_ddr_len    <= '0;
      r_ddr_conf   <= 1'b0;
      r_inflight   <= 1'b0;
      r_skid_cnt   <= 2'd0;
    end else begin
      r_ddr_conf <= w_accept && (bus.line_num != '0);
      r_inflight <= w_rd_en;
      if (w_accept) begin
        r_line_num   <= bus.line_num;
        r_lines_read <= '0;
        r_rb_st      <= bus.rb_st_addr;
        r_ddr_addr   <= bus.ddr_st_addr;
        r_ddr_len    <= bus.line_num * SINGLE_LEN'(DATA_LEN);
      end else if (w_rd_en) begin
        r_lines_read <= r_lines_read + SINGLE_LEN'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_skid_cnt <= r_skid_cnt + 2'd1;
        2'b01:   r_skid_cnt <= r_skid_cnt - 2'd1;
        default: r_skid_cnt <= r_skid_cnt;
      endcase
    end
  end

  // Skid payload needs no reset; r_skid_cnt qualifies it.
  always_ff @(posedge clk) begin
    if (w_pop)                                r_skid0 <= (r_skid_cnt == 2'd2) ? r_skid1 : w_rb_lanes;
    else if (w_push && r_skid_cnt == 2'd0)    r_skid0 <= w_rb_lanes;
    if (w_push && ((r_skid_cnt == 2'd1 && !w_pop) || r_skid_cnt == 2'd2))
      r_skid1 <= w_rb_lanes;
  end

  assign bus.ddr_st_addr_out = r_ddr_addr;
  assign bus.ddr_len         = r_ddr_len;
  assign bus.ddr_conf        = r_ddr_conf;
  assign bus.rb_addr         = r_rb_st + ADDR_LEN'(r_lines_read);
  assign bus.rb_rd_en        = w_rd_en;
  assign bus.ddr_fifo_wr     = w_wr;
  assign bus.ddr_fifo_data   = w_wr_data;
  assign bus.done            = (r_state == S_DONE);
  assign bus.idle            = (r_state == S_IDLE);
endmodule

// File: tb/tb_result_ddr_writeback_control.sv
// Self-checking bench for result_ddr_writeback_control: buffer model, write monitor, scenario tasks.
module tb_result_ddr_writeback_control;
  localparam int DAL = 32, AL = 16, DL = 64, SL = 24, LW = DL * 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_ddr_writeback_control_if #(.DDR_ADDR_LEN(DAL), .ADDR_LEN(AL), .DATA_LEN(DL), .SINGLE_LEN(SL)) bus();
  result_ddr_writeback_control #(.DDR_ADDR_LEN(DAL), .ADDR_LEN(AL), .DATA_LEN(DL), .SINGLE_LEN(SL))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int passed = 0, total = 0;
  int unsigned salt = 0;
  bit lane_id_mode = 1'b0;

  bit mon_en = 1'b0;
  int cyc = 0;
  int n_reads, n_conf, n_done, wr_full_viol, occ_viol, first_rd_cyc, conf_pulse_cyc, done_cyc;
  logic [LW-1:0] wq[$];
  int            wcyc[$];
  logic [AL-1:0] aq[$];

  // Content of result buffer line a (8 lanes); lane_id_mode makes lane k hold k.
  function automatic logic [LW-1:0] line_val(input logic [AL-1:0] a);
    logic [7:0][DL-1:0] l;
    for (int k = 0; k < 8; k++)
      l[k] = lane_id_mode ? DL'(k) : DL'({a, 8'(k), 8'hA5, salt});
    return l;
  endfunction

  // What the DDR side should see for buffer line a.
  function automatic logic [LW-1:0] exp_line(input logic [AL-1:0] a);
    logic [7:0][DL-1:0] src, dst;
    src = line_val(a);
    for (int k = 0; k < 8; k++) begin
`ifdef WB_LANE_REVERSE_EN
      dst[k] = src[7-k];
`else
      dst[k] = src[k];
`endif
    end
    return dst;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.rb_rd_en) bus.rb_data <= line_val(bus.rb_addr);

  always @(negedge clk) if (mon_en) begin
    if (bus.rb_rd_en) begin
      if (n_reads == 0) first_rd_cyc = cyc;
      n_reads++;
      aq.push_back(bus.rb_addr);
    end
    if (bus.ddr_conf) begin n_conf++; conf_pulse_cyc = cyc; end
    if (bus.done) begin n_done++; done_cyc = cyc; end
    if (bus.ddr_fifo_wr && bus.ddr_fifo_full) wr_full_viol++;
    if (n_reads - wq.size() > 2) occ_viol++;
    if (bus.ddr_fifo_wr) begin wq.push_back(bus.ddr_fifo_data); wcyc.push_back(cyc); end
  end

  task automatic clear_mon();
    n_reads = 0; n_conf = 0; n_done = 0; wr_full_viol = 0; occ_viol = 0;
    first_rd_cyc = -1; conf_pulse_cyc = -1; done_cyc = -1;
    wq.delete(); wcyc.delete(); aq.delete();
  endtask

  task automatic start_job(input int n, input logic [AL-1:0] ra, input logic [DAL-1:0] da, output int tconf);
    @(posedge clk); #1;
    bus.conf = 1'b1; bus.line_num = SL'(n); bus.rb_st_addr = ra; bus.ddr_st_addr = da;
    tconf = cyc;
    @(posedge clk); #1;
    bus.conf = 1'b0;
  endtask

  // mode 0: full low, 1: full 1/0 every 3 cycles, 2: random full
  task automatic run_full(input int mode, input int budget, input string nm);
    for (int i = 0; i < budget && n_done == 0; i++) begin
      @(posedge clk); #1;
      case (mode)
        0:       bus.ddr_fifo_full = 1'b0;
        1:       bus.ddr_fifo_full = ((i / 3) % 2 == 0);
        default: bus.ddr_fifo_full = ($urandom_range(0, 99) < 40);
      endcase
    end
    bus.ddr_fifo_full = 1'b0;
    total++;
    if (n_done == 0) $display("FAIL %s_done_timeout: done count %0d, required 1", nm, n_done);
    else passed++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.ddr_conf, bus.rb_rd_en, bus.ddr_fifo_wr, bus.done, bus.idle} !== 5'b00001)
      $display("FAIL reset_ctrl: conf/rd/wr/done/idle=%b, required 00001",
               {bus.ddr_conf, bus.rb_rd_en, bus.ddr_fifo_wr, bus.done, bus.idle});
    else passed++;
    total++;
    if ({bus.ddr_st_addr_out, bus.ddr_len, bus.rb_addr} !== '0 || bus.ddr_fifo_data !== '0)
      $display("FAIL reset_data: addr=%h len=%h rb_addr=%h, required 0", bus.ddr_st_addr_out, bus.ddr_len, bus.rb_addr);
    else passed++;
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int t;
    salt = $urandom; clear_mon();
    start_job(4, 16'h0010, 32'h8000_0000, t);
    run_full(0, 60, "basic");
    total++;
    if (conf_pulse_cyc != t + 1 || n_conf != 1)
      $display("FAIL basic_ddr_conf: cycle %0d count %0d, required cycle %0d count 1", conf_pulse_cyc, n_conf, t + 1);
    else passed++;
    total++;
    if (bus.ddr_st_addr_out !== 32'h8000_0000 || bus.ddr_len !== 24'd256)
      $display("FAIL basic_desc: addr=%h len=%0d, required 80000000 256", bus.ddr_st_addr_out, bus.ddr_len);
    else passed++;
    total++;
    if (first_rd_cyc < t + 1) $display("FAIL basic_first_rd: cycle %0d, required >= %0d", first_rd_cyc, t + 1);
    else passed++;
    total++;
    if (aq.size() != 4 || wq.size() != 4) $display("FAIL basic_counts: reads %0d writes %0d, required 4 4", aq.size(), wq.size());
    else passed++;
    for (int i = 0; i < aq.size() && i < 4; i++) begin
      total++;
      if (aq[i] !== AL'(16'h10 + i)) $display("FAIL basic_rb_addr%0d: %h, required %h", i, aq[i], AL'(16'h10 + i));
      else passed++;
    end
    for (int i = 0; i < wq.size() && i < 4; i++) begin
      total++;
      if (wq[i] !== exp_line(AL'(16'h10 + i))) $display("FAIL basic_data%0d: %h, required %h", i, wq[i][63:0], exp_line(AL'(16'h10 + i)) >> 0);
      else passed++;
    end
    if (wcyc.size() == 4) begin
      total++;
      if (wcyc[3] - wcyc[0] != 3) $display("FAIL basic_consecutive: span %0d, required 3", wcyc[3] - wcyc[0]);
      else passed++;
      total++;
      if (done_cyc != wcyc[3] + 1) $display("FAIL basic_done_cycle: %0d, required %0d", done_cyc, wcyc[3] + 1);
      else passed++;
    end
    total++;
    if (bus.idle !== 1'b1 || n_done != 1) $display("FAIL basic_idle: idle=%b done_count=%0d, required 1 1", bus.idle, n_done);
    else passed++;
  endtask

  task automatic test_backpressure();
    int t;
    logic [AL-1:0] ra;
    salt = $urandom; ra = AL'($urandom); clear_mon();
    start_job(8, ra, $urandom, t);
    run_full(1, 200, "bp");
    total++;
    if (wq.size() != 8 || n_reads != 8) $display("FAIL bp_counts: writes %0d reads %0d, required 8 8", wq.size(), n_reads);
    else passed++;
    total++;
    if (wr_full_viol != 0 || occ_viol != 0)
      $display("FAIL bp_rules: writes_while_full %0d over_occupancy %0d, required 0 0", wr_full_viol, occ_viol);
    else passed++;
    for (int i = 0; i < wq.size() && i < 8; i++) begin
      total++;
      if (wq[i] !== exp_line(AL'(ra + i))) $display("FAIL bp_data%0d: %h, required %h", i, wq[i][63:0], exp_line(AL'(ra + i)) >> 0);
      else passed++;
    end
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      int t, n;
      logic [AL-1:0] ra;
      logic [DAL-1:0] da;
      n = $urandom_range(1, 20); ra = AL'($urandom); da = $urandom; salt = $urandom;
      clear_mon();
      start_job(n, ra, da, t);
      run_full(2, 400, "rand");
      total++;
      if (bus.ddr_st_addr_out !== da || bus.ddr_len !== SL'(n * DL))
        $display("FAIL rand_desc%0d: addr=%h len=%0d, required %h %0d", j, bus.ddr_st_addr_out, bus.ddr_len, da, n * DL);
      else passed++;
      total++;
      if (wq.size() != n || wr_full_viol != 0 || occ_viol != 0)
        $display("FAIL rand_rules%0d: writes %0d full_viol %0d occ_viol %0d, required %0d 0 0", j, wq.size(), wr_full_viol, occ_viol, n);
      else passed++;
      for (int i = 0; i < wq.size() && i < n; i++) begin
        total++;
        if (wq[i] !== exp_line(AL'(ra + i))) $display("FAIL rand_data%0d_%0d: %h, required %h", j, i, wq[i][63:0], exp_line(AL'(ra + i)) >> 0);
        else passed++;
      end
    end
  endtask

  task automatic test_zero_len();
    int t;
    clear_mon();
    start_job(0, 16'h1234, 32'h1111_0000, t);
    @(negedge clk);
    total++;
    if (bus.done !== 1'b1 || bus.ddr_conf !== 1'b0)
      $display("FAIL zero_done_at_T1: done=%b ddr_conf=%b, required 1 0", bus.done, bus.ddr_conf);
    else passed++;
    repeat (4) @(negedge clk);
    total++;
    if (n_reads != 0 || n_conf != 0 || n_done != 1 || wq.size() != 0 || bus.idle !== 1'b1)
      $display("FAIL zero_activity: reads %0d conf %0d done %0d writes %0d idle %b, required 0 0 1 0 1",
               n_reads, n_conf, n_done, wq.size(), bus.idle);
    else passed++;
  endtask

  task automatic test_wrap_overlap();
    int t;
    salt = $urandom; clear_mon();
    start_job(3, 16'hFFFE, 32'h0000_4000, t);
    #1 bus.conf = 1'b1; bus.line_num = 24'd10; bus.ddr_st_addr = 32'hDEAD_0000;
    @(posedge clk); #1 bus.conf = 1'b0;
    run_full(0, 60, "wrap");
    total++;
    if (aq.size() != 3 || aq[0] !== 16'hFFFE || aq[1] !== 16'hFFFF || aq[2] !== 16'h0000)
      $display("FAIL wrap_rb_addr: count %0d, required FFFE FFFF 0000", aq.size());
    else passed++;
    total++;
    if (wq.size() != 3 || n_conf != 1 || bus.ddr_st_addr_out !== 32'h0000_4000)
      $display("FAIL overlap_ignored: writes %0d conf %0d addr %h, required 3 1 00004000", wq.size(), n_conf, bus.ddr_st_addr_out);
    else passed++;
    for (int i = 0; i < wq.size() && i < 3; i++) begin
      total++;
      if (wq[i] !== exp_line(AL'(17'h0FFFE + i))) $display("FAIL wrap_data%0d: %h, required %h", i, wq[i][63:0], exp_line(AL'(17'h0FFFE + i)) >> 0);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_job();
    int t;
    logic [AL-1:0] ra;
    salt = $urandom; ra = AL'($urandom); clear_mon();
    start_job(16, ra, 32'h2000_0000, t);
    for (int i = 0; i < 100 && wq.size() < 5; i++) @(negedge clk);
    total++;
    if (wq.size() < 5) $display("FAIL rstmid_progress: writes %0d, required >= 5", wq.size());
    else passed++;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.ddr_conf, bus.rb_rd_en, bus.ddr_fifo_wr, bus.done, bus.idle} !== 5'b00001 ||
        bus.ddr_st_addr_out !== '0 || bus.ddr_len !== '0 || bus.ddr_fifo_data !== '0)
      $display("FAIL rstmid_outputs: conf/rd/wr/done/idle=%b addr=%h len=%h, required 00001 0 0",
               {bus.ddr_conf, bus.rb_rd_en, bus.ddr_fifo_wr, bus.done, bus.idle}, bus.ddr_st_addr_out, bus.ddr_len);
    else passed++;
    clear_mon();
    repeat (5) @(negedge clk);
    total++;
    if (n_reads != 0 || wq.size() != 0) $display("FAIL rstmid_quiet: reads %0d writes %0d, required 0 0", n_reads, wq.size());
    else passed++;
    clear_mon();
    start_job(2, ra, 32'h3000_0000, t);
    run_full(0, 60, "rstmid_new");
    total++;
    if (wq.size() != 2 || n_done != 1) $display("FAIL rstmid_new_job: writes %0d done %0d, required 2 1", wq.size(), n_done);
    else passed++;
    for (int i = 0; i < wq.size() && i < 2; i++) begin
      total++;
      if (wq[i] !== exp_line(AL'(ra + i))) $display("FAIL rstmid_data%0d: %h, required %h", i, wq[i][63:0], exp_line(AL'(ra + i)) >> 0);
      else passed++;
    end
  endtask

  task automatic test_lane_order();
    int t;
    logic [7:0][DL-1:0] got;
    lane_id_mode = 1'b1; clear_mon();
    start_job(1, AL'($urandom), 32'h0, t);
    run_full(0, 40, "lane");
    total++;
    if (wq.size() != 1) $display("FAIL lane_count: writes %0d, required 1", wq.size());
    else passed++;
    if (wq.size() >= 1) begin
      got = wq[0];
      for (int k = 0; k < 8; k++) begin
`ifdef WB_LANE_REVERSE_EN
        total++;
        if (got[k] !== DL'(7 - k)) $display("FAIL lane%0d: %0d, required %0d", k, got[k], 7 - k);
        else passed++;
`else
        total++;
        if (got[k] !== DL'(k)) $display("FAIL lane%0d: %0d, required %0d", k, got[k], k);
        else passed++;
`endif
      end
    end
    lane_id_mode = 1'b0;
  endtask

  initial begin
    bus.conf = 1'b0; bus.line_num = '0; bus.ddr_st_addr = '0; bus.rb_st_addr = '0;
    bus.ddr_fifo_full = 1'b0;
    clear_mon();
    test_reset();
    test_basic();
    test_backpressure();
    test_random_jobs();
    test_zero_len();
    test_wrap_overlap();
    test_reset_mid_job();
    test_lane_order();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time exceeded, %0d/%0d so far", passed, total);
    $fatal(1);
  end
endmodule
